mem_word_port: RTL and testbench

- Sits directly upstream of spi_ram_controller, which is instantiated with DATA_WIDTH_BYTES=1 and ADDR_BITS=16, and is the CPU's only path to external SPI RAM.
- Arbitrates between an instruction-fetch port and a data port.
- Splits each 16-bit word access into two byte transactions (low byte first), reassembles read words and returns a one-cycle ack to the winning port.

---
 rtl/mem_word_port_if.sv | 27 ++
 rtl/mem_word_port.sv | 130 +++++++++++++
 tb/tb_mem_word_port.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_word_port_if.sv
// CPU-side bundle for mem_word_port: instruction-fetch port and data port.
// Word addresses are ADDR_BITS-1 wide; data words are 16 bits.
interface mem_word_port_if #(
  parameter int ADDR_BITS = 16
);
  logic                 if_req;
  logic [ADDR_BITS-2:0] if_addr;
  logic [15:0]          if_rdata;
  logic                 if_ack;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-2:0] d_addr;
  logic [15:0]          d_wdata;
  logic [15:0]          d_rdata;
  logic                 d_ack;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_rdata, if_ack, d_rdata, d_ack
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_rdata, if_ack, d_rdata, d_ack
  );
endinterface

// File: rtl/mem_word_port.sv
// Arbitrates fetch and data word accesses onto a byte-wide SPI RAM controller,
// issuing low then high byte and returning a one-cycle ack to the winner.
module mem_word_port #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_word_port_if.slave       cpu,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_start_read,
  output logic                 ram_start_write,
  input  logic [7:0]           ram_rdata,
  input  logic                 ram_busy
);

  typedef enum logic [2:0] {
    IDLE, LO_START, LO_WAIT, HI_START, HI_WAIT, DONE
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t                 state_q, state_d;
  logic                   port_q, port_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-2:0]   waddr_q, waddr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [7:0]             hold_lo_q, hold_lo_d;
  logic [15:0]            if_rdata_q, if_rdata_d;
  logic [15:0]            d_rdata_q, d_rdata_d;
  logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]             ram_wdata_q, ram_wdata_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      port_q       <= PORT_FETCH;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      hold_lo_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      last_grant_q <= PORT_FETCH;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      hold_lo_q    <= hold_lo_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    hold_lo_d    = hold_lo_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    last_grant_d = last_grant_q;
    // On a tie the data port wins unless it was the last one served.
    grant_data   = cpu.d_req && (!cpu.if_req || (last_grant_q == PORT_FETCH));

    case (state_q)
      IDLE: begin
        if (cpu.d_req || cpu.if_req) begin
          port_d      = grant_data ? PORT_DATA : PORT_FETCH;
          we_d        = grant_data && cpu.d_we;
          waddr_d     = grant_data ? cpu.d_addr : cpu.if_addr;
          wdata_d     = grant_data ? cpu.d_wdata : 16'h0000;
          ram_addr_d  = {waddr_d, 1'b0};
          ram_wdata_d = wdata_d[7:0];
          state_d     = LO_START;
        end
      end
      LO_START: state_d = LO_WAIT;
      LO_WAIT: begin
        if (!ram_busy) begin
          if (!we_q) hold_lo_d = ram_rdata;
          ram_addr_d  = {waddr_q, 1'b1};
          ram_wdata_d = wdata_q[15:8];
          state_d     = HI_START;
        end
      end
      HI_START: state_d = HI_WAIT;
      HI_WAIT: begin
        if (!ram_busy) begin
          // Result lands in the port register as DONE begins, aligned with ack.
          if (!we_q) begin
            if (port_q == PORT_DATA) d_rdata_d  = {ram_rdata, hold_lo_q};
            else                     if_rdata_d = {ram_rdata, hold_lo_q};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        last_grant_d = port_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign ram_start_read  = ((state_q == LO_START) || (state_q == HI_START)) && !we_q;
  assign ram_start_write = ((state_q == LO_START) || (state_q == HI_START)) && we_q;

  assign cpu.if_rdata = if_rdata_q;
  assign cpu.d_rdata  = d_rdata_q;
  assign cpu.if_ack   = (state_q == DONE) && (port_q == PORT_FETCH);
  assign cpu.d_ack    = (state_q == DONE) && (port_q == PORT_DATA);

endmodule

// File: tb/tb_mem_word_port.sv
// Scoreboard bench for mem_word_port with a behavioural SPI RAM controller (B=3)
// and a byte-array reference memory for expected read words.
module tb_mem_word_port;
  localparam int B = 3;

  typedef struct {
    bit          is_read;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
  } ram_op_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_start_read, ram_start_write, ram_busy;

  mem_word_port_if #(.ADDR_BITS(16)) bus ();

  mem_word_port #(.ADDR_BITS(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cpu            (bus),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_start_read (ram_start_read),
    .ram_start_write(ram_start_write),
    .ram_rdata      (ram_rdata),
    .ram_busy       (ram_busy)
  );

  always #5 clk = ~clk;

  // Controller model: busy rises the edge after a start and lasts B cycles.
  logic [7:0] ram_mem [0:65535];
  int         busy_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_cnt  <= 0;
      ram_rdata <= 8'h00;
    end else if (ram_start_read || ram_start_write) begin
      busy_cnt <= B;
      if (ram_start_write) ram_mem[ram_addr] <= ram_wdata;
      else                 ram_rdata <= ram_mem[ram_addr];
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign ram_busy = (busy_cnt != 0);

  logic [7:0]  ref_mem [0:65535];
  logic [15:0] exp_f_q [$];
  exp_t        exp_d_q [$];
  ram_op_t     ram_log [$];
  bit          ack_seq [$];
  logic [15:0] d_model;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          f_ack_cnt = 0;
  int          d_ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic [15:0] w;
    exp_t        e;
    bit          prev_if_ack, prev_d_ack;
    prev_if_ack = 1'b0;
    prev_d_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.if_ack) begin
          check("if_ack_single", 32'(prev_if_ack), 32'd0);
          if (exp_f_q.size() == 0) check("if_ack_expected", 32'd1, 32'd0);
          else begin
            w = exp_f_q.pop_front();
            check("if_rdata", 32'(bus.if_rdata), 32'(w));
          end
          f_ack_cnt++;
          ack_seq.push_back(1'b0);
          $display("[%0t] fetch ack rdata=%04h", $time, bus.if_rdata);
        end
        if (bus.d_ack) begin
          check("d_ack_single", 32'(prev_d_ack), 32'd0);
          if (exp_d_q.size() == 0) check("d_ack_expected", 32'd1, 32'd0);
          else begin
            e = exp_d_q.pop_front();
            check(e.is_read ? "d_rdata_read" : "d_rdata_hold", 32'(bus.d_rdata), 32'(e.word));
          end
          d_ack_cnt++;
          ack_seq.push_back(1'b1);
          $display("[%0t] data ack rdata=%04h", $time, bus.d_rdata);
        end
        if (ram_start_read || ram_start_write) begin
          check("start_exclusive", 32'(ram_start_read & ram_start_write), 32'd0);
          check("start_while_busy", 32'(ram_busy), 32'd0);
          ram_log.push_back('{ram_start_write, ram_addr, ram_wdata});
        end
      end
      prev_if_ack = bus.if_ack;
      prev_d_ack  = bus.d_ack;
    end
  end

  task automatic push_d(input bit we, input logic [14:0] a, input logic [15:0] w);
    exp_t e;
    if (we) begin
      ref_mem[{a, 1'b0}] = w[7:0];
      ref_mem[{a, 1'b1}] = w[15:8];
      e.is_read = 1'b0;
    end else begin
      d_model   = {ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]};
      e.is_read = 1'b1;
    end
    e.word = d_model;
    exp_d_q.push_back(e);
  endtask

  task automatic fetch_txn(input logic [14:0] a, output int lat);
    int issue;
    bit ok;
    @(posedge clk); #1;
    exp_f_q.push_back({ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]});
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    issue = cyc;
    lat = -1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.if_ack) begin
        ok = 1'b1;
        lat = cyc - issue;
        break;
      end
    end
    if (!ok) check("if_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic data_txn(input bit we, input logic [14:0] a, input logic [15:0] w, input int hold_extra);
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i <= hold_extra; i++) push_d(we, a, w);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = w;
    bus.d_req   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.d_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("d_ack_timeout", 32'd0, 32'd1);
    repeat (1 + hold_extra) @(posedge clk);
    #1 bus.d_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_if_rdata"}, 32'(bus.if_rdata), 32'd0);
    check({tag, "_d_rdata"}, 32'(bus.d_rdata), 32'd0);
    check({tag, "_if_ack"}, 32'(bus.if_ack), 32'd0);
    check({tag, "_d_ack"}, 32'(bus.d_ack), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_start_read"}, 32'(ram_start_read), 32'd0);
    check({tag, "_start_write"}, 32'(ram_start_write), 32'd0);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    exp_f_q.delete();
    exp_d_q.delete();
    d_model = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_d_acks(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (d_ack_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check(name, 32'(d_ack_cnt), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          lat, base_ack, base_log;
    bit          ok;
    logic [7:0]  v;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    d_model = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ram_mem[i] <= v;
      ref_mem[i] = v;
    end
    ram_mem[16'h0010] <= 8'h34; ref_mem[16'h0010] = 8'h34;
    ram_mem[16'h0011] <= 8'h12; ref_mem[16'h0011] = 8'h12;

    repeat (3) @(posedge clk); #1;
    check_idle_outputs("reset");
    rstn = 1'b1;

    // Fetch read: latency 2B+5 and two byte reads, low first
    ram_log.delete();
    fetch_txn(15'h0008, lat);
    check("fetch_latency", 32'(lat), 32'(2 * B + 5));
    check("fetch_if_rdata", 32'(bus.if_rdata), 32'h1234);
    check("fetch_start_count", 32'(ram_log.size()), 32'd2);
    if (ram_log.size() == 2) begin
      check("fetch_lo_addr", 32'(ram_log[0].addr), 32'h0010);
      check("fetch_hi_addr", 32'(ram_log[1].addr), 32'h0011);
      check("fetch_is_read", 32'(ram_log[0].we | ram_log[1].we), 32'd0);
    end

    // Write at top word, d_rdata must hold the previous read
    data_txn(1'b0, 15'h0008, 16'h0, 0);
    ram_log.delete();
    data_txn(1'b1, 15'h7FFF, 16'hBEEF, 0);
    check("write_start_count", 32'(ram_log.size()), 32'd2);
    if (ram_log.size() == 2) begin
      check("write_lo", {15'd0, ram_log[0].we, ram_log[0].addr}, {15'd0, 1'b1, 16'hFFFE});
      check("write_lo_data", 32'(ram_log[0].data), 32'h00EF);
      check("write_hi", {15'd0, ram_log[1].we, ram_log[1].addr}, {15'd0, 1'b1, 16'hFFFF});
      check("write_hi_data", 32'(ram_log[1].data), 32'h00BE);
    end
    data_txn(1'b0, 15'h7FFF, 16'h0, 0);
    check("readback_7fff", 32'(bus.d_rdata), 32'h0000BEEF);

    // Round-robin after reset: simultaneous requests, data first, then alternation
    apply_reset();
    ack_seq.delete();
    fork
      begin
        int l;
        for (int i = 0; i < 4; i++) fetch_txn(15'(i * 3), l);
      end
      begin
        for (int i = 0; i < 4; i++) data_txn(1'b0, 15'(16'h4000 + i), 16'h0, 0);
      end
    join
    check("rr_ack_count", 32'(ack_seq.size()), 32'd8);
    for (int i = 0; i < ack_seq.size() && i < 8; i++)
      check($sformatf("rr_order_%0d", i), 32'(ack_seq[i]), 32'((i % 2) == 0));

    // Requester holding req one cycle too long gets exactly one extra transaction
    base_ack = d_ack_cnt;
    base_log = ram_log.size();
    data_txn(1'b0, 15'h0030, 16'h0, 1);
    wait_d_acks(base_ack + 2, "violation_ack_timeout");
    repeat (15) @(posedge clk); #1;
    check("violation_acks", 32'(d_ack_cnt - base_ack), 32'd2);
    check("violation_starts", 32'(ram_log.size() - base_log), 32'd4);
    base_ack = d_ack_cnt;
    base_log = ram_log.size();
    data_txn(1'b0, 15'h0031, 16'h0, 0);
    repeat (15) @(posedge clk); #1;
    check("compliant_acks", 32'(d_ack_cnt - base_ack), 32'd1);
    check("compliant_starts", 32'(ram_log.size() - base_log), 32'd2);

    // Reset during HI_WAIT of a read: everything clears, no ack
    base_log = ram_log.size();
    @(posedge clk); #1;
    bus.d_we = 1'b0; bus.d_addr = 15'h0020; bus.d_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ram_log.size() >= base_log + 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("hi_start_timeout", 32'(ram_log.size() - base_log), 32'd2);
    @(posedge clk); #2;
    base_ack = d_ack_cnt;
    rstn = 1'b0;
    bus.d_req = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_f_q.delete();
    exp_d_q.delete();
    d_model = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (15) @(posedge clk); #1;
    check("midreset_no_ack", 32'(d_ack_cnt), 32'(base_ack));
    data_txn(1'b0, 15'h0020, 16'h0, 0);
    check("post_reset_read", 32'(bus.d_rdata), {16'd0, ref_mem[16'h0041], ref_mem[16'h0040]});

    // Inputs scrambled after grant must not reach the RAM
    ram_log.delete();
    @(posedge clk); #1;
    push_d(1'b1, 15'h4010, 16'hA55A);
    bus.d_we = 1'b1; bus.d_addr = 15'h4010; bus.d_wdata = 16'hA55A; bus.d_req = 1'b1;
    @(posedge clk);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      bus.d_addr  = 15'($urandom);
      bus.d_wdata = 16'($urandom);
      @(negedge clk);
      if (bus.d_ack) ok = 1'b1;
      else @(posedge clk);
    end
    if (!ok) check("scramble_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    check("scramble_starts", 32'(ram_log.size()), 32'd2);
    if (ram_log.size() == 2) begin
      check("scramble_lo", {ram_log[0].addr, 8'd0, ram_log[0].data}, {16'h8020, 8'd0, 8'h5A});
      check("scramble_hi", {ram_log[1].addr, 8'd0, ram_log[1].data}, {16'h8021, 8'd0, 8'hA5});
    end
    data_txn(1'b0, 15'h4010, 16'h0, 0);

    // Random traffic on both ports, disjoint address regions
    fork
      begin
        int l;
        for (int i = 0; i < 20; i++) fetch_txn(15'($urandom_range(0, 255)), l);
      end
      begin
        for (int i = 0; i < 20; i++)
          data_txn(1'($urandom_range(0, 1)), 15'(16'h4000 + $urandom_range(0, 63)), 16'($urandom), 0);
      end
    join
    repeat (5) @(posedge clk); #1;
    check("fetch_queue_drained", 32'(exp_f_q.size()), 32'd0);
    check("data_queue_drained", 32'(exp_d_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
